interrupt_ctrl: RTL and testbench

Parametrised multi-source machine-mode interrupt controller; the successor to the single-input interrupter in the CPU top level. It synchronises NCH external sources and latches them as edge- or level-triggered pending bits. It arbitrates by fixed priority and drives `g_interrupt` towards the execution stage, with a claim/complete handshake that tracks the in-service channel. Non-nesting: one channel is in service at a time.

---
 rtl/interrupt_ctrl.sv | 144 ++++++++++++++
 tb/tb_interrupt_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ctrl.sv
// Multi-source machine-mode interrupt controller: synchronised edge/level pending bits,
// fixed lowest-index-first priority, and a non-nesting claim/complete handshake.
module interrupt_ctrl #(
    parameter int unsigned    NCH         = 8,
    parameter int unsigned    IDW         = 3,
    parameter logic [NCH-1:0] EDGE_MASK   = {NCH{1'b1}},
    parameter int unsigned    SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] interrupt_in,
    input  logic [NCH-1:0] irq_enable,
    input  logic           csr_meie,
    input  logic           interrupt_clear,
    input  logic           claim,
    input  logic           complete,
    input  logic [IDW-1:0] complete_id,
    output logic           g_interrupt,
    output logic [IDW-1:0] claim_id,
    output logic [NCH-1:0] irq_pending
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_SERVICE
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
    logic [NCH-1:0] s, s_prev_q;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] in_svc_q, in_svc_d;
    logic [NCH-1:0] edge_set, pend_clr, eligible, claim_oh;
    logic [IDW-1:0] claim_id_q, claim_id_d, win_id;
    logic           g_int_q, g_int_d;
    logic           any_elig, claim_fire, complete_hit;

    assign s            = sync_q[SYNC_STAGES-1];
    assign claim_oh     = NCH'(1) << claim_id_q;
    assign eligible     = pend_q & irq_enable & ~in_svc_q;
    assign claim_fire   = (state_q == ST_ASSERT) && claim && !interrupt_clear;
    assign complete_hit = (state_q == ST_SERVICE) && complete && (complete_id == claim_id_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            s_prev_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], interrupt_in};
            s_prev_q <= s;
        end
    end

    // Edge channels: a fresh edge overrides any clear in the same cycle.
    // Level channels simply track the synchronised source.
    always_comb begin
        edge_set = s & ~s_prev_q & EDGE_MASK;
        pend_clr = '0;
        if (interrupt_clear) begin
            pend_clr = '1;
        end else if (claim_fire) begin
            pend_clr = claim_oh;
        end
        pend_d = (EDGE_MASK & ((pend_q & ~pend_clr) | edge_set)) | (~EDGE_MASK & s);
    end

    always_comb begin
        in_svc_d = in_svc_q;
        if (interrupt_clear) begin
            in_svc_d = '0;
        end else if (claim_fire) begin
            in_svc_d = in_svc_q | claim_oh;
        end else if (complete_hit) begin
            in_svc_d = in_svc_q & ~claim_oh;
        end
    end

    always_comb begin
        win_id   = '0;
        any_elig = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (eligible[i] && !any_elig) begin
                win_id   = IDW'(i);
                any_elig = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (csr_meie && any_elig) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (claim) begin
                    state_d = ST_SERVICE;
                end else if (!csr_meie || !(|(eligible & claim_oh))) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (complete_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (interrupt_clear) state_d = ST_IDLE;
    end

    always_comb begin
        g_int_d    = (state_d == ST_ASSERT);
        claim_id_d = claim_id_q;
        if ((state_q == ST_IDLE) && (state_d == ST_ASSERT)) claim_id_d = win_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            in_svc_q   <= '0;
            g_int_q    <= 1'b0;
            claim_id_q <= '0;
        end else begin
            pend_q     <= pend_d;
            in_svc_q   <= in_svc_d;
            g_int_q    <= g_int_d;
            claim_id_q <= claim_id_d;
        end
    end

    assign g_interrupt = g_int_q;
    assign claim_id    = claim_id_q;
    assign irq_pending = pend_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: channel 0 level-triggered, channels 1..7 edge-triggered.
module tb_interrupt_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] interrupt_in;
    logic [7:0] irq_enable;
    logic       csr_meie;
    logic       interrupt_clear;
    logic       claim;
    logic       complete;
    logic [2:0] complete_id;
    logic       g_interrupt;
    logic [2:0] claim_id;
    logic [7:0] irq_pending;

    int checks;
    int failures;

    interrupt_ctrl #(
        .NCH(8),
        .IDW(3),
        .EDGE_MASK(8'hFE),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .interrupt_in(interrupt_in),
        .irq_enable(irq_enable),
        .csr_meie(csr_meie),
        .interrupt_clear(interrupt_clear),
        .claim(claim),
        .complete(complete),
        .complete_id(complete_id),
        .g_interrupt(g_interrupt),
        .claim_id(claim_id),
        .irq_pending(irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        interrupt_in    = '0;
        irq_enable      = 8'hFF;
        csr_meie        = 1'b1;
        interrupt_clear = 1'b0;
        claim           = 1'b0;
        complete        = 1'b0;
        complete_id     = '0;

        tick(2);
        chk("reset_g", 32'(g_interrupt), 32'd0);
        chk("reset_id", 32'(claim_id), 32'd0);
        chk("reset_pend", 32'(irq_pending), 32'h00);
        rst_n = 1'b1;
        tick(2);

        // single edge on channel 3
        interrupt_in[3] = 1'b1;
        tick(2);
        chk("e3_pend_edge2", 32'(irq_pending), 32'h00);
        tick(1);
        chk("e3_pend_edge3", 32'(irq_pending), 32'h08);
        chk("e3_g_edge3", 32'(g_interrupt), 32'd0);
        tick(1);
        chk("e3_g_edge4", 32'(g_interrupt), 32'd1);
        chk("e3_id_edge4", 32'(claim_id), 32'd3);
        interrupt_in[3] = 1'b0;
        claim = 1'b1;
        tick(1);
        claim = 1'b0;
        chk("e3_claim_g", 32'(g_interrupt), 32'd0);
        chk("e3_claim_pend", 32'(irq_pending), 32'h00);
        chk("e3_claim_id", 32'(claim_id), 32'd3);
        complete = 1'b1;
        complete_id = 3'd3;
        tick(1);
        complete = 1'b0;
        chk("e3_done_g", 32'(g_interrupt), 32'd0);
        tick(1);
        chk("e3_idle_g", 32'(g_interrupt), 32'd0);

        // priority: channels 2 and 5 together
        interrupt_in[2] = 1'b1;
        interrupt_in[5] = 1'b1;
        tick(3);
        chk("pri_pend", 32'(irq_pending), 32'h24);
        tick(1);
        chk("pri_g1", 32'(g_interrupt), 32'd1);
        chk("pri_id2", 32'(claim_id), 32'd2);
        claim = 1'b1;
        tick(1);
        claim = 1'b0;
        chk("pri_claim_pend", 32'(irq_pending), 32'h20);
        complete = 1'b1;
        complete_id = 3'd2;
        tick(1);
        complete = 1'b0;
        chk("pri_done_g", 32'(g_interrupt), 32'd0);
        tick(1);
        chk("pri_reassert_g", 32'(g_interrupt), 32'd1);
        chk("pri_id5", 32'(claim_id), 32'd5);
        claim = 1'b1;
        tick(1);
        claim = 1'b0;
        complete = 1'b1;
        complete_id = 3'd5;
        tick(1);
        complete = 1'b0;
        interrupt_in = '0;
        tick(3);
        chk("pri_quiet_g", 32'(g_interrupt), 32'd0);

        // masking: global enable, then per-channel enable during ASSERT
        csr_meie = 1'b0;
        interrupt_in[1] = 1'b1;
        tick(5);
        chk("mask_meie_g", 32'(g_interrupt), 32'd0);
        chk("mask_meie_pend", 32'(irq_pending), 32'h02);
        csr_meie = 1'b1;
        tick(1);
        chk("mask_meie_on_g", 32'(g_interrupt), 32'd1);
        chk("mask_meie_on_id", 32'(claim_id), 32'd1);
        irq_enable = 8'hFD;
        tick(1);
        chk("mask_en_off_g", 32'(g_interrupt), 32'd0);
        tick(1);
        chk("mask_en_stay_g", 32'(g_interrupt), 32'd0);
        chk("mask_en_pend", 32'(irq_pending), 32'h02);
        interrupt_clear = 1'b1;
        tick(1);
        interrupt_clear = 1'b0;
        chk("mask_clear_pend", 32'(irq_pending), 32'h00);
        irq_enable = 8'hFF;
        interrupt_in[1] = 1'b0;
        tick(3);
        chk("mask_quiet_g", 32'(g_interrupt), 32'd0);

        // level channel 0 held high through claim and complete
        interrupt_in[0] = 1'b1;
        tick(4);
        chk("lvl_g", 32'(g_interrupt), 32'd1);
        chk("lvl_id", 32'(claim_id), 32'd0);
        claim = 1'b1;
        tick(1);
        claim = 1'b0;
        chk("lvl_claim_g", 32'(g_interrupt), 32'd0);
        chk("lvl_claim_pend", 32'(irq_pending), 32'h01);
        complete = 1'b1;
        complete_id = 3'd0;
        tick(1);
        complete = 1'b0;
        chk("lvl_done_g", 32'(g_interrupt), 32'd0);
        tick(1);
        chk("lvl_reassert_g", 32'(g_interrupt), 32'd1);
        chk("lvl_reassert_id", 32'(claim_id), 32'd0);
        interrupt_in[0] = 1'b0;
        tick(2);
        chk("lvl_drop_pend2", 32'(irq_pending), 32'h01);
        tick(1);
        chk("lvl_drop_pend3", 32'(irq_pending), 32'h00);
        chk("lvl_drop_g3", 32'(g_interrupt), 32'd1);
        tick(1);
        chk("lvl_drop_g4", 32'(g_interrupt), 32'd0);

        // new edge on channel 4 coinciding with claim(4)
        interrupt_in[4] = 1'b1;
        tick(1);
        interrupt_in[4] = 1'b0;
        tick(3);
        chk("sim_g", 32'(g_interrupt), 32'd1);
        chk("sim_id", 32'(claim_id), 32'd4);
        interrupt_in[4] = 1'b1;
        tick(2);
        claim = 1'b1;
        tick(1);
        claim = 1'b0;
        chk("sim_claim_g", 32'(g_interrupt), 32'd0);
        chk("sim_setwins_pend", 32'(irq_pending), 32'h10);
        complete = 1'b1;
        complete_id = 3'd6;
        tick(1);
        complete = 1'b0;
        chk("sim_badid_g1", 32'(g_interrupt), 32'd0);
        tick(1);
        chk("sim_badid_g2", 32'(g_interrupt), 32'd0);
        complete = 1'b1;
        complete_id = 3'd4;
        tick(1);
        complete = 1'b0;
        tick(1);
        chk("sim_reassert_g", 32'(g_interrupt), 32'd1);
        chk("sim_reassert_id", 32'(claim_id), 32'd4);
        interrupt_clear = 1'b1;
        claim = 1'b1;
        tick(1);
        interrupt_clear = 1'b0;
        claim = 1'b0;
        chk("clr_claim_g", 32'(g_interrupt), 32'd0);
        chk("clr_claim_pend", 32'(irq_pending), 32'h00);
        interrupt_in[4] = 1'b0;
        tick(3);
        interrupt_in[4] = 1'b1;
        tick(4);
        chk("clr_insvc_free_g", 32'(g_interrupt), 32'd1);
        chk("clr_insvc_free_id", 32'(claim_id), 32'd4);
        claim = 1'b1;
        tick(1);
        claim = 1'b0;
        complete = 1'b1;
        complete_id = 3'd4;
        tick(1);
        complete = 1'b0;
        interrupt_in = '0;
        tick(3);

        // reset in the middle of SERVICE
        interrupt_in[6] = 1'b1;
        interrupt_in[7] = 1'b1;
        tick(4);
        chk("rst_pre_g", 32'(g_interrupt), 32'd1);
        chk("rst_pre_id", 32'(claim_id), 32'd6);
        claim = 1'b1;
        tick(1);
        claim = 1'b0;
        chk("rst_svc_pend", 32'(irq_pending), 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_g", 32'(g_interrupt), 32'd0);
        chk("rst_async_id", 32'(claim_id), 32'd0);
        chk("rst_async_pend", 32'(irq_pending), 32'h00);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk("rst_lat_g3", 32'(g_interrupt), 32'd0);
        chk("rst_lat_pend3", 32'(irq_pending), 32'hC0);
        tick(1);
        chk("rst_lat_g4", 32'(g_interrupt), 32'd1);
        chk("rst_lat_id4", 32'(claim_id), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
